dmem_responder_cache: RTL and testbench

- Memory-side responder for the pipelined core's data port.
- Accepts the core's dmem request: dmem_read/dmem_write, word-aligned address, byte enables and write data.
- Returns read data with a dmem_resp handshake. The core holds its request and stalls until dmem_resp is asserted.
- Implemented as a direct-mapped, write-back, write-allocate cache. It services misses through a single-beat 256-bit line interface to physical memory.

---
 rtl/dmem_responder_cache_if.sv | 34 +++
 rtl/dmem_responder_cache.sv | 141 ++++++++++++++
 tb/tb_dmem_responder_cache.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_cache_if.sv
// Core data-port and physical-memory line port bundled for the data cache.
// Latency: n/a (wiring only).
// Backpressure: core holds its request until dmem_resp; pmem holds its request until pmem_resp.
interface dmem_responder_cache_if;
    logic         dmem_read;
    logic         dmem_write;
    logic [31:0]  dmem_address;
    logic [31:0]  dmem_wdata;
    logic [3:0]   dmem_byte_enable;
    logic [31:0]  dmem_rdata;
    logic         dmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    // The cache side: consumes core requests and fill data, produces responses and line requests.
    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        input  pmem_rdata, pmem_resp,
        output dmem_rdata, dmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    // The environment side: the core plus physical memory.
    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        output pmem_rdata, pmem_resp,
        input  dmem_rdata, dmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/dmem_responder_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a single-beat 256-bit line port.
// Latency: hits respond in the request cycle; misses respond one cycle after the fill completes.
// Backpressure: core stalls until dmem_resp; writeback/fill requests are held until pmem_resp.
module dmem_responder_cache #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_responder_cache_if.slave bus
);
    localparam int LINES = 2 ** S_INDEX;

    // A line viewed as words of bytes, so a store merges per byte lane without bit arithmetic.
    typedef logic [(1 << (S_OFFSET - 2)) - 1:0][3:0][7:0] line_t;
    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t               state_q, state_d;
    line_t                data_q  [LINES];
    line_t                data_d  [LINES];
    logic [S_TAG-1:0]     tag_q   [LINES];
    logic [S_TAG-1:0]     tag_d   [LINES];
    logic [LINES-1:0]     valid_q, valid_d;
    logic [LINES-1:0]     dirty_q, dirty_d;
    // Line address of the miss in service, so the transfer survives the core dropping its request.
    logic [31-S_OFFSET:0] miss_q, miss_d;
    logic [31:0]          rdata_q, rdata_d;

    logic [S_TAG-1:0]     req_tag;
    logic [S_INDEX-1:0]   req_idx;
    logic [S_INDEX-1:0]   miss_idx;
    logic [S_OFFSET-3:0]  req_word;
    logic                 req;
    logic                 hit;
    line_t                merged;
    logic                 unused_addr_bits;

    assign req_tag          = bus.dmem_address[31 -: S_TAG];
    assign req_idx          = bus.dmem_address[S_OFFSET +: S_INDEX];
    assign req_word         = bus.dmem_address[S_OFFSET-1:2];
    assign miss_idx         = miss_q[S_INDEX-1:0];
    assign req              = bus.dmem_read | bus.dmem_write;
    assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_addr_bits = ^bus.dmem_address[1:0];

    // Store data merged into the addressed line, enabled byte lanes only.
    always_comb begin
        merged = data_q[req_idx];
        for (int b = 0; b < 4; b++) begin
            if (bus.dmem_byte_enable[b]) begin
                merged[req_word][b] = bus.dmem_wdata[8*b +: 8];
            end
        end
    end

    // Next-state, array updates and all port outputs; IDLE also serves hits.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        miss_d  = miss_q;
        rdata_d = rdata_q;

        bus.dmem_resp    = 1'b0;
        bus.dmem_rdata   = rdata_q;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        bus.dmem_resp = 1'b1;
                        // Read and write together is a write; read data is then not meaningful.
                        if (bus.dmem_write) begin
                            data_d[req_idx]  = merged;
                            dirty_d[req_idx] = 1'b1;
                        end else begin
                            rdata_d        = data_q[req_idx][req_word];
                            bus.dmem_rdata = rdata_d;
                        end
                    end else begin
                        miss_d  = bus.dmem_address[31:S_OFFSET];
                        state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[miss_idx], miss_idx, {S_OFFSET{1'b0}}};
                bus.pmem_wdata   = data_q[miss_idx];
                if (bus.pmem_resp) begin
                    dirty_d[miss_idx] = 1'b0;
                    state_d           = FILL;
                end
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {miss_q, {S_OFFSET{1'b0}}};
                if (bus.pmem_resp) begin
                    data_d[miss_idx]  = bus.pmem_rdata;
                    tag_d[miss_idx]   = miss_q[31-S_OFFSET -: S_TAG];
                    valid_d[miss_idx] = 1'b1;
                    dirty_d[miss_idx] = 1'b0;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state; reset forgets every line, discarding dirty data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            miss_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            miss_q  <= miss_d;
            rdata_q <= rdata_d;
        end
    end

    // Line data and tags need no reset: they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end
endmodule

// File: tb/tb_dmem_responder_cache.sv
module tb_dmem_responder_cache;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_responder_cache_if bus();
    dmem_responder_cache dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } xfer_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fill_cyc = -10;
    int pm_delay = 1;

    // Physical memory as lines, the core's flat view as words, and slot residency.
    logic [255:0] phys    [logic [31:0]];
    logic [255:0] preload [logic [31:0]];
    logic [31:0]  ref_mem [logic [31:0]];
    xfer_t        xq [$];
    bit           res_valid [8];
    logic [31:0]  res_line  [8];
    bit           res_dirty [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        if (preload.exists(la)) return preload[la];
        for (int i = 0; i < 8; i++)
            l[32*i +: 32] = ((la + 32'(4 * i)) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        return l;
    endfunction

    function automatic logic [255:0] phys_line(input logic [31:0] la);
        if (phys.exists(la)) return phys[la];
        return init_line(la);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0]  wa;
        logic [255:0] l;
        wa = {a[31:2], 2'b00};
        if (ref_mem.exists(wa)) return ref_mem[wa];
        l = phys_line({a[31:5], 5'b0});
        return l[32 * int'(a[4:2]) +: 32];
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = ref_word(la + 32'(4 * i));
        return l;
    endfunction

    // Memory responder and bus-rule monitor, sampling mid-cycle away from input changes.
    initial begin
        int           wcnt;
        logic [31:0]  hold_addr;
        logic [255:0] hold_wdata;
        xfer_t        x;
        wcnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            #2;
            check_eq("pmem_rd_wr_overlap", bus.pmem_read & bus.pmem_write, 0);
            check_eq("dmem_resp_only_idle", bus.dmem_resp & (bus.pmem_read | bus.pmem_write), 0);
            if (rst) begin
                wcnt = 0;
                bus.pmem_resp = 1'b0;
            end else if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
            end else if (bus.pmem_read | bus.pmem_write) begin
                if (wcnt == 0) begin
                    hold_addr  = bus.pmem_address;
                    hold_wdata = bus.pmem_wdata;
                end else begin
                    check_eq("pmem_addr_stable", bus.pmem_address, hold_addr);
                    check_eq("pmem_wdata_stable", bus.pmem_wdata, hold_wdata);
                end
                if (wcnt >= pm_delay) begin
                    x.wr   = bus.pmem_write;
                    x.addr = bus.pmem_address;
                    if (bus.pmem_write) begin
                        x.data = bus.pmem_wdata;
                        phys[x.addr] = x.data;
                    end else begin
                        x.data = phys_line(x.addr);
                        bus.pmem_rdata = x.data;
                        fill_cyc = cyc;
                    end
                    xq.push_back(x);
                    bus.pmem_resp = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic check_xfers(input bit exp_wb, input logic [31:0] victim,
                               input logic [255:0] vdata, input logic [31:0] la);
        xfer_t x;
        if (exp_wb) begin
            check_eq("wb_issued", xq.size() > 0, 1);
            if (xq.size() > 0) begin
                x = xq.pop_front();
                check_eq("wb_is_write", x.wr, 1);
                check_eq("wb_addr", x.addr, victim);
                check_eq("wb_data", x.data, vdata);
            end
        end
        check_eq("fill_issued", xq.size() > 0, 1);
        if (xq.size() > 0) begin
            x = xq.pop_front();
            check_eq("fill_is_read", x.wr, 0);
            check_eq("fill_addr", x.addr, la);
        end
    endtask

    // One core request, called at a falling edge; checks response, data and line traffic.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rdata_o);
        logic [31:0]  la, victim, w;
        logic [255:0] vdata;
        int           idx, n;
        bit           hit, exp_wb, got;
        la     = {a[31:5], 5'b0};
        idx    = int'(a[7:5]);
        hit    = res_valid[idx] && (res_line[idx] == la);
        exp_wb = !hit && res_valid[idx] && res_dirty[idx];
        victim = res_line[idx];
        vdata  = ref_line(victim);
        xq.delete();
        bus.dmem_read        = rd;
        bus.dmem_write       = wr;
        bus.dmem_address     = a;
        bus.dmem_wdata       = wd;
        bus.dmem_byte_enable = be;
        got = 0;
        n = 0;
        rdata_o = '0;
        while (!got && n < 60) begin
            #1;
            if (bus.dmem_resp) begin
                got = 1;
                rdata_o = bus.dmem_rdata;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("dmem_resp_seen", got, 1);
        if (got && hit) check_eq("hit_zero_wait", n, 0);
        if (got && !hit) check_eq("miss_resp_after_fill", cyc, fill_cyc + 1);
        if (got && rd && !wr) check_eq("rdata", rdata_o, ref_word(a));
        @(negedge clk);
        bus.dmem_read  = 1'b0;
        bus.dmem_write = 1'b0;
        if (wr) begin
            w = ref_word(a);
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_mem[{a[31:2], 2'b00}] = w;
        end
        if (!hit) check_xfers(exp_wb, victim, vdata, la);
        check_eq("no_extra_pmem", xq.size(), 0);
        res_dirty[idx] = (hit && res_dirty[idx]) || wr;
        res_valid[idx] = 1;
        res_line[idx]  = la;
    endtask

    // Read miss dropped by the core one cycle in: the transfer finishes but no response appears.
    task automatic abandon_read(input logic [31:0] a);
        logic [31:0]  la, victim;
        logic [255:0] vdata;
        int           idx;
        bit           exp_wb, got;
        la     = {a[31:5], 5'b0};
        idx    = int'(a[7:5]);
        exp_wb = res_valid[idx] && res_dirty[idx];
        victim = res_line[idx];
        vdata  = ref_line(victim);
        xq.delete();
        bus.dmem_read    = 1'b1;
        bus.dmem_address = a;
        @(negedge clk);
        bus.dmem_read = 1'b0;
        got = 0;
        repeat (20) begin
            #1;
            if (bus.dmem_resp) got = 1;
            @(negedge clk);
        end
        check_eq("abandoned_no_resp", got, 0);
        check_xfers(exp_wb, victim, vdata, la);
        res_valid[idx] = 1;
        res_line[idx]  = la;
        res_dirty[idx] = 0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            res_valid[i] = 0;
            res_dirty[i] = 0;
            res_line[i]  = '0;
        end
        ref_mem.delete();
        xq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.dmem_read  = 1'b0;
        bus.dmem_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_dmem_resp", bus.dmem_resp, 0);
        check_eq("rst_pmem_read", bus.pmem_read, 0);
        check_eq("rst_pmem_write", bus.pmem_write, 0);
        check_eq("rst_dmem_rdata", bus.dmem_rdata, 0);
        check_eq("rst_pmem_address", bus.pmem_address, 0);
        check_eq("rst_pmem_wdata", bus.pmem_wdata, 0);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
    endtask

    // Reset lands in the second writeback cycle; the dirty line must be lost.
    task automatic reset_mid_wb(input logic [31:0] a);
        pm_delay = 5;
        xq.delete();
        bus.dmem_read    = 1'b1;
        bus.dmem_address = a;
        @(negedge clk);
        #1;
        check_eq("wb_started", bus.pmem_write, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst_mid_wb_pmem_write", bus.pmem_write, 0);
        check_eq("rst_mid_wb_pmem_read", bus.pmem_read, 0);
        check_eq("rst_mid_wb_dmem_resp", bus.dmem_resp, 0);
        check_eq("rst_mid_wb_no_xfer", xq.size(), 0);
        rst = 1'b0;
        bus.dmem_read = 1'b0;
        clear_model();
        pm_delay = 1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  r;
        logic [255:0] l;
        rst = 1'b1;
        bus.dmem_read        = 1'b0;
        bus.dmem_write       = 1'b0;
        bus.dmem_address     = '0;
        bus.dmem_wdata       = '0;
        bus.dmem_byte_enable = '0;
        l = init_line(32'h100);
        l[63:32] = 32'hDEAD_BEEF;
        preload[32'h100] = l;
        @(negedge clk);
        do_reset();

        // Cold fill then zero-wait hit.
        pm_delay = 1;
        do_req(1, 0, 32'h104, 0, 0, r);
        check_eq("tp_fill_word1", r, 32'hDEAD_BEEF);
        do_req(1, 0, 32'h104, 0, 0, r);
        check_eq("tp_hit_word1", r, 32'hDEAD_BEEF);

        // Partial store merge.
        do_req(0, 1, 32'h104, 32'h1122_3344, 4'b0110, r);
        do_req(1, 0, 32'h104, 0, 0, r);
        check_eq("tp_byte_merge", r, 32'hDE22_33EF);

        // Conflict on index 0 forces writeback of the modified line.
        do_req(1, 0, 32'h200, 0, 0, r);

        // Slow fill.
        pm_delay = 5;
        do_req(1, 0, 32'h3A8, 0, 0, r);
        pm_delay = 1;

        // Read and write together behave as a write.
        do_req(1, 0, 32'h108, 0, 0, r);
        do_req(1, 1, 32'h108, 32'hCAFE_F00D, 4'b1111, r);
        do_req(1, 0, 32'h108, 0, 0, r);
        check_eq("tp_rw_as_write", r, 32'hCAFE_F00D);

        // Empty byte-enable still dirties the line.
        do_req(0, 1, 32'h3A4, 32'hFFFF_FFFF, 4'b0000, r);
        do_req(1, 0, 32'h7A0, 0, 0, r);
        do_req(1, 0, 32'h3A4, 0, 0, r);

        // Top-of-memory line, last index.
        do_req(0, 1, 32'hFFFF_FFE0, 32'h0BAD_C0DE, 4'b1111, r);
        do_req(1, 0, 32'hFFFF_FFFC, 0, 0, r);
        do_req(1, 0, 32'h0000_00E0, 0, 0, r);
        do_req(1, 0, 32'hFFFF_FFE0, 0, 0, r);
        check_eq("wrap_readback", r, 32'h0BAD_C0DE);

        // Core gives up mid-miss.
        do_req(0, 1, 32'hFFFF_FFE4, 32'h7777_8888, 4'b1111, r);
        abandon_read(32'h5E0);

        // Reset during writeback.
        do_req(0, 1, 32'h44, 32'h1234_5678, 4'b1111, r);
        reset_mid_wb(32'h444);
        do_req(1, 0, 32'h44, 0, 0, r);

        // Randomised traffic over a few tags per index, including the all-ones tag.
        for (int i = 0; i < 400; i++) begin
            int          op, ts;
            logic [23:0] tg;
            logic [31:0] ra;
            ts = $urandom_range(0, 4);
            tg = (ts == 4) ? 24'hFF_FFFF : 24'(ts);
            ra = {tg, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            op = $urandom_range(0, 9);
            pm_delay = $urandom_range(0, 3);
            do_req((op < 5) || (op == 9), op >= 5, ra, $urandom, 4'($urandom), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
